mul2x2_seq_scheduler: RTL

//  Sequences a single exact 2x2-bit multiplier core to compute a WIDTH x WIDTH unsigned product.

---
 rtl/mul_sched_pkg.sv | 22 ++
 rtl/mul2x2_core.sv | 13 +
 rtl/mul2x2_seq_scheduler.sv | 125 ++++++++++++
 3 files changed

// File: rtl/mul_sched_pkg.sv
// Shared types and helpers for the radix-4 sequenced multiplier.
// The digit helper works on a fixed maximum width so any operand width up to MAX_VEC_W can use it.
package mul_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int DIGIT_W   = 2;
  localparam int CORE_P_W  = 4;
  localparam int MAX_VEC_W = 64;

  function automatic logic [DIGIT_W-1:0] digit_sel(input logic [MAX_VEC_W-1:0] vec,
                                                   input int unsigned idx);
    logic [MAX_VEC_W-1:0] shifted;
    shifted = vec >> (idx * DIGIT_W);
    return shifted[DIGIT_W-1:0];
  endfunction

endpackage

// File: rtl/mul2x2_core.sv
// Exact combinational 2x2-bit unsigned multiplier.
// It can be replaced by generated approximate variants with the same ports.
module mul2x2_core
  import mul_sched_pkg::*;
(
  input  logic [DIGIT_W-1:0]  a,
  input  logic [DIGIT_W-1:0]  b,
  output logic [CORE_P_W-1:0] p
);

  assign p = CORE_P_W'(a) * CORE_P_W'(b);

endmodule

// File: rtl/mul2x2_seq_scheduler.sv
// Computes WIDTH x WIDTH unsigned products by issuing one radix-4 digit pair per cycle
// to a single 2x2 core and accumulating the shifted partial products.
module mul2x2_seq_scheduler
  import mul_sched_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic               busy
);

  localparam int DIGITS = WIDTH / 2;
  localparam int CW     = $clog2(DIGITS);
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  state_t state, state_next;

  logic [WIDTH-1:0]    a_reg, b_reg;
  logic [CW-1:0]       i_cnt, j_cnt;
  logic [2*WIDTH-1:0]  acc, partial, sum;
  logic [DIGIT_W-1:0]  core_a, core_b;
  logic [CORE_P_W-1:0] core_p;
  logic [CW+1:0]       shamt;
  logic                accept, last_op;

  // Core inputs come only from registered operands and counters.
  assign core_a  = digit_sel(MAX_VEC_W'(a_reg), 32'(i_cnt));
  assign core_b  = digit_sel(MAX_VEC_W'(b_reg), 32'(j_cnt));
  assign shamt   = ({2'b00, i_cnt} + {2'b00, j_cnt}) << 1;
  assign partial = (2*WIDTH)'(core_p) << shamt;
  assign sum     = acc + partial;
  assign last_op = (i_cnt == LAST) && (j_cnt == LAST);
  assign accept  = in_valid && in_ready;

  mul2x2_core u_core (
    .a (core_a),
    .b (core_b),
    .p (core_p)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !flush;
        if (in_valid && !flush) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_op) state_next = DONE;
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  // flush wins over every other update, including the DONE handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      acc       <= '0;
      i_cnt     <= '0;
      j_cnt     <= '0;
      out_p     <= '0;
      out_valid <= 1'b0;
    end else if (flush) begin
      acc       <= '0;
      i_cnt     <= '0;
      j_cnt     <= '0;
      out_p     <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_reg <= in_a;
            b_reg <= in_b;
            acc   <= '0;
            i_cnt <= '0;
            j_cnt <= '0;
          end
        end
        RUN: begin
          acc <= sum;
          if (last_op) begin
            i_cnt     <= '0;
            j_cnt     <= '0;
            out_p     <= sum;
            out_valid <= 1'b1;
          end else if (j_cnt == LAST) begin
            j_cnt <= '0;
            i_cnt <= i_cnt + CW'(1);
          end else begin
            j_cnt <= j_cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
